wb_cache_control: RTL and testbench
===================================

WB_CACHE_CONTROL -- requirements
Module: wb_cache_control

Interface
REQ-001 Parameter WAYS, default 2, associativity; legal values 2, 4, 8.
REQ-002 Parameter WAY_W, default $clog2(WAYS), encoded way-index width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 mem_read  in  1  CPU read request, held until mem_resp.
REQ-006 mem_write  in  1  CPU write request, held until mem_resp.
REQ-007 mem_resp  out  1  one-cycle CPU completion pulse.
REQ-008 pmem_read / pmem_write  out  1 each  physical-memory line read / write request.
REQ-009 pmem_resp  in  1  physical-memory completion pulse.
REQ-010 way_hit  in  WAYS  per-way tag-match-and-valid vector from the datapath.
REQ-011 way_valid / way_dirty  in  WAYS each  per-way valid and dirty bits of the indexed set.
REQ-012 lru_way  in  WAY_W  least-recently-used way of the indexed set.
REQ-013 load_way  out  WAYS  one-hot load enable for data, tag and valid of one way.
REQ-014 set_dirty / clr_dirty  out  1 each  dirty-bit update for the way selected by load_way.
REQ-015 load_lru  out  1  update LRU with access_way.
REQ-016 access_way  out  WAY_W  way being accessed: hit way in HIT, latched victim otherwise.
REQ-017 cache_in_mux_sel  out  1  0 = line from pmem, 1 = CPU write merge.
REQ-018 pmem_addr_sel  out  1  0 = CPU address, 1 = victim tag address (write-back).

Function
REQ-019 States SHALL be HIT, WRITEBACK, FETCH and ALLOCATE.
REQ-020 In HIT, with a request and any way_hit bit set, the block SHALL assert mem_resp and load_lru in the same cycle; access_way SHALL be the lowest-index set bit.
REQ-021 On a write hit, the block SHALL also assert load_way(hit way), cache_in_mux_sel=1 and set_dirty.
REQ-022 When mem_read and mem_write are both high, the block SHALL treat the request as a write.
REQ-023 On a request with way_hit all zero, the block SHALL latch the victim: the lowest-index invalid way, else lru_way.
REQ-024 On that miss, the next state SHALL be WRITEBACK if the victim is valid and dirty, else FETCH.
REQ-025 WRITEBACK SHALL hold pmem_write=1 and pmem_addr_sel=1 until pmem_resp, then go to FETCH.
REQ-026 FETCH SHALL hold pmem_read=1 and pmem_addr_sel=0 until pmem_resp, then go to ALLOCATE.
REQ-027 ALLOCATE SHALL last one cycle with load_way(victim), cache_in_mux_sel=0 and clr_dirty, then return to HIT.
REQ-028 After ALLOCATE, the retried access SHALL hit in HIT, giving miss latency of 2 + pmem cycles (+ write-back pmem cycles).
REQ-029 pmem_read and pmem_write SHALL never be high together; mem_resp SHALL never be asserted outside HIT.
REQ-030 pmem_resp SHALL be ignored in HIT and ALLOCATE.
REQ-031 An idle cycle (no request) in HIT SHALL drive all outputs to 0 and hold state.
REQ-032 The latched victim SHALL be stable from miss detection until ALLOCATE, regardless of lru_way changes.

Reset
REQ-033 rst_n low SHALL immediately force state=HIT, victim=0 and every output to 0, including mid-WRITEBACK or mid-FETCH.
REQ-034 After rst_n rises, the first rising edge SHALL evaluate HIT normally.

Structure
REQ-035 The state enum and WAYS-derived constants SHALL live in shared package cache_types.
REQ-036 Victim choice (first-invalid priority encoder, else LRU) SHALL be a sub-module, victim_select, parametrised by WAYS.

Verification
REQ-037 WAYS=2, read with way_hit=2'b10 -> mem_resp=1, load_lru=1, access_way=1 in the same cycle.
REQ-038 Write miss, way_valid=2'b01 -> victim 1, FETCH (pmem_read) for 3 cycles until pmem_resp, ALLOCATE with load_way=2'b10, then a write hit with set_dirty.
REQ-039 WAYS=4, read miss with all ways valid, way_dirty=4'b0100, lru_way=2 -> WRITEBACK with pmem_addr_sel=1, then FETCH, then load_way=4'b0100.
REQ-040 rst_n low during FETCH with pmem_read=1 -> pmem_read=0 immediately; after release, state is HIT and no stale ALLOCATE occurs.
REQ-041 lru_way changing 0->1 during FETCH -> ALLOCATE still loads the latched way 0.
REQ-042 mem_read=mem_write=1 on a hit -> write path taken (load_way, set_dirty), single mem_resp.

Source files
------------

// File: rtl/cache_types.sv
// -----------------------------------------------------------------------------
// cache_types
//   Shared types and WAYS-derived constants for the write-back cache
//   controller slice.
//
//   Contents:
//     state_e    - controller state encoding (HIT, WRITEBACK, FETCH, ALLOCATE)
//     MAX_WAYS   - largest supported associativity
//     MAX_WAY_W  - way-index width at MAX_WAYS
//     way_w_for  - encoded way-index width for a given associativity
//     legal_ways - true for the supported associativities (2, 4, 8)
// -----------------------------------------------------------------------------
package cache_types;

    typedef enum logic [1:0] {
        ST_HIT       = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_FETCH     = 2'd2,
        ST_ALLOCATE  = 2'd3
    } state_e;

    localparam int MAX_WAYS  = 8;
    localparam int MAX_WAY_W = $clog2(MAX_WAYS);

    function automatic int way_w_for(input int ways);
        return $clog2(ways);
    endfunction

    function automatic bit legal_ways(input int ways);
        return (ways == 2) || (ways == 4) || (ways == 8);
    endfunction

endpackage : cache_types

// File: rtl/wb_cache_control_if.sv
// -----------------------------------------------------------------------------
// wb_cache_control_if
//   Bundles the CPU handshake, physical-memory handshake and datapath
//   status/control signals of the cache controller.
//
//   Parameters:
//     WAYS  - associativity (2, 4 or 8)
//     WAY_W - encoded way-index width
//
//   Modports:
//     slave  - the controller: takes requests and way status, drives controls
//     master - the surrounding CPU / memory / datapath side
//
//   Signals:
//     mem_read, mem_write      CPU request, held until mem_resp
//     mem_resp                 one-cycle CPU completion pulse
//     pmem_read, pmem_write    physical-memory line requests
//     pmem_resp                physical-memory completion pulse
//     way_hit                  per-way tag match and valid
//     way_valid, way_dirty     per-way status bits of the indexed set
//     lru_way                  least-recently-used way of the indexed set
//     load_way                 one-hot load enable for data/tag/valid
//     set_dirty, clr_dirty     dirty-bit update for the loaded way
//     load_lru                 update LRU with access_way
//     access_way               way being accessed
//     cache_in_mux_sel         0 = line from pmem, 1 = CPU write merge
//     pmem_addr_sel            0 = CPU address, 1 = victim tag address
// -----------------------------------------------------------------------------
interface wb_cache_control_if
    import cache_types::*;
#(
    parameter int WAYS  = 2,
    parameter int WAY_W = way_w_for(WAYS)
);

    logic             mem_read;
    logic             mem_write;
    logic             mem_resp;
    logic             pmem_read;
    logic             pmem_write;
    logic             pmem_resp;
    logic [WAYS-1:0]  way_hit;
    logic [WAYS-1:0]  way_valid;
    logic [WAYS-1:0]  way_dirty;
    logic [WAY_W-1:0] lru_way;
    logic [WAYS-1:0]  load_way;
    logic             set_dirty;
    logic             clr_dirty;
    logic             load_lru;
    logic [WAY_W-1:0] access_way;
    logic             cache_in_mux_sel;
    logic             pmem_addr_sel;

    modport slave (
        input  mem_read, mem_write, pmem_resp,
        input  way_hit, way_valid, way_dirty, lru_way,
        output mem_resp, pmem_read, pmem_write,
        output load_way, set_dirty, clr_dirty, load_lru,
        output access_way, cache_in_mux_sel, pmem_addr_sel
    );

    modport master (
        output mem_read, mem_write, pmem_resp,
        output way_hit, way_valid, way_dirty, lru_way,
        input  mem_resp, pmem_read, pmem_write,
        input  load_way, set_dirty, clr_dirty, load_lru,
        input  access_way, cache_in_mux_sel, pmem_addr_sel
    );

endinterface : wb_cache_control_if

// File: rtl/victim_select.sv
// -----------------------------------------------------------------------------
// victim_select
//   Chooses the replacement way for a miss: the lowest-index invalid way if
//   the set has one, otherwise the LRU way. Purely combinational.
//
//   Parameters:
//     WAYS  - associativity (2, 4 or 8)
//     WAY_W - encoded way-index width
//
//   Ports:
//     way_valid  in   WAYS   valid bits of the indexed set
//     lru_way    in   WAY_W  least-recently-used way
//     victim     out  WAY_W  selected replacement way
// -----------------------------------------------------------------------------
module victim_select
    import cache_types::*;
#(
    parameter int WAYS  = 2,
    parameter int WAY_W = way_w_for(WAYS)
) (
    input  logic [WAYS-1:0]  way_valid,
    input  logic [WAY_W-1:0] lru_way,
    output logic [WAY_W-1:0] victim
);

    // Scanning from the top down lets the lowest invalid way win without a
    // separate "found" flag.
    always_comb begin
        victim = lru_way;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!way_valid[i]) begin
                victim = WAY_W'(i);
            end
        end
    end

endmodule : victim_select

// File: rtl/wb_cache_control.sv
// -----------------------------------------------------------------------------
// wb_cache_control
//   Control FSM for a set-associative write-back, write-allocate cache.
//   Hits complete in the HIT state in a single cycle. A miss latches a
//   victim way, writes it back to physical memory if it is valid and dirty,
//   fetches the new line, loads it in ALLOCATE and returns to HIT, where the
//   still-held CPU request is replayed and hits.
//
//   Parameters:
//     WAYS  - associativity (2, 4 or 8)
//     WAY_W - encoded way-index width
//
//   Ports:
//     clk    in  sole clock, rising edge
//     rst_n  in  asynchronous active-low reset; forces HIT and quiet outputs
//     bus    wb_cache_control_if.slave - CPU, pmem and datapath signals
// -----------------------------------------------------------------------------
module wb_cache_control
    import cache_types::*;
#(
    parameter int WAYS  = 2,
    parameter int WAY_W = way_w_for(WAYS)
) (
    input  logic                clk,
    input  logic                rst_n,
    wb_cache_control_if.slave   bus
);

    state_e           state;
    state_e           state_next;
    logic [WAY_W-1:0] victim_q;
    logic [WAY_W-1:0] victim_d;
    logic [WAY_W-1:0] victim_sel;
    logic [WAY_W-1:0] hit_idx;
    logic             hit_any;
    logic             req;
    logic             is_write;
    logic             victim_wb;

    victim_select #(
        .WAYS  (WAYS),
        .WAY_W (WAY_W)
    ) u_victim_select (
        .way_valid (bus.way_valid),
        .lru_way   (bus.lru_way),
        .victim    (victim_sel)
    );

    // Lowest-index set bit of way_hit; several ways should never match, but
    // the priority keeps access_way well defined if they do.
    always_comb begin
        hit_idx = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (bus.way_hit[i]) begin
                hit_idx = WAY_W'(i);
            end
        end
    end

    assign hit_any   = |bus.way_hit;
    assign req       = bus.mem_read | bus.mem_write;
    // A simultaneous read and write is serviced as a write.
    assign is_write  = bus.mem_write;
    assign victim_wb = bus.way_valid[victim_sel] & bus.way_dirty[victim_sel];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours, matching real hardware.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_HIT;
            victim_q <= '0;
        end else begin
            state    <= state_next;
            victim_q <= victim_d;
        end
    end

    // NOTE: every signal driven here gets a default before the case statement;
    // a path that leaves one unassigned would otherwise infer a latch.
    always_comb begin
        state_next           = state;
        victim_d             = victim_q;
        bus.mem_resp         = 1'b0;
        bus.pmem_read        = 1'b0;
        bus.pmem_write       = 1'b0;
        bus.load_way         = '0;
        bus.set_dirty        = 1'b0;
        bus.clr_dirty        = 1'b0;
        bus.load_lru         = 1'b0;
        bus.access_way       = '0;
        bus.cache_in_mux_sel = 1'b0;
        bus.pmem_addr_sel    = 1'b0;

        // NOTE: the outputs are decoded from the state but also from live
        // request inputs in HIT, so the reset flop alone cannot silence them;
        // gating with rst_n keeps every output low for the whole reset pulse.
        if (rst_n) begin
            unique case (state)
                ST_HIT: begin
                    if (req) begin
                        if (hit_any) begin
                            bus.mem_resp   = 1'b1;
                            bus.load_lru   = 1'b1;
                            bus.access_way = hit_idx;
                            if (is_write) begin
                                bus.load_way         = WAYS'(1) << hit_idx;
                                bus.cache_in_mux_sel = 1'b1;
                                bus.set_dirty        = 1'b1;
                            end
                        end else begin
                            // The victim is captured once here and held until
                            // ALLOCATE, so LRU updates from other traffic
                            // cannot redirect the fill.
                            victim_d   = victim_sel;
                            state_next = victim_wb ? ST_WRITEBACK : ST_FETCH;
                        end
                    end
                end

                ST_WRITEBACK: begin
                    bus.pmem_write    = 1'b1;
                    bus.pmem_addr_sel = 1'b1;
                    bus.access_way    = victim_q;
                    if (bus.pmem_resp) begin
                        state_next = ST_FETCH;
                    end
                end

                ST_FETCH: begin
                    bus.pmem_read  = 1'b1;
                    bus.access_way = victim_q;
                    if (bus.pmem_resp) begin
                        state_next = ST_ALLOCATE;
                    end
                end

                ST_ALLOCATE: begin
                    // The freshly fetched line is clean; the replayed write in
                    // HIT will set the dirty bit again if needed.
                    bus.load_way   = WAYS'(1) << victim_q;
                    bus.clr_dirty  = 1'b1;
                    bus.access_way = victim_q;
                    state_next     = ST_HIT;
                end

                default: begin
                    state_next = ST_HIT;
                end
            endcase
        end
    end

endmodule : wb_cache_control

// File: tb/tb_wb_cache_control.sv
// -----------------------------------------------------------------------------
// tb_wb_cache_control
//   Scoreboard bench for wb_cache_control. Two instances are built, WAYS=2
//   and WAYS=4. Stimulus pushes the hand-derived output pattern of every
//   non-idle cycle into a per-instance queue; a monitor on each instance
//   pops and compares whenever any control output is active, and flags any
//   activity the stimulus did not announce. Quiet cycles (reset, idle,
//   ignored pmem_resp) are compared directly by the stimulus.
//
//   Observation word layout (both instances, zero-extended):
//     [18] mem_resp [17] load_lru [16] set_dirty [15] clr_dirty
//     [14] cache_in_mux_sel [13] pmem_read [12] pmem_write [11] pmem_addr_sel
//     [10:8] access_way [7:0] load_way
// -----------------------------------------------------------------------------
module tb_wb_cache_control;

    typedef struct {
        string       name;
        logic [31:0] v;
    } exp_t;

    logic clk;
    logic rst_n;

    exp_t q2[$];
    exp_t q4[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    wb_cache_control_if #(.WAYS(2)) bus2 ();
    wb_cache_control_if #(.WAYS(4)) bus4 ();

    wb_cache_control #(.WAYS(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    wb_cache_control #(.WAYS(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- helpers
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] obs2();
        return {13'b0, bus2.mem_resp, bus2.load_lru, bus2.set_dirty, bus2.clr_dirty,
                bus2.cache_in_mux_sel, bus2.pmem_read, bus2.pmem_write, bus2.pmem_addr_sel,
                2'b0, bus2.access_way, 6'b0, bus2.load_way};
    endfunction

    function automatic logic [31:0] obs4();
        return {13'b0, bus4.mem_resp, bus4.load_lru, bus4.set_dirty, bus4.clr_dirty,
                bus4.cache_in_mux_sel, bus4.pmem_read, bus4.pmem_write, bus4.pmem_addr_sel,
                1'b0, bus4.access_way, 4'b0, bus4.load_way};
    endfunction

    function automatic logic [31:0] pat(input bit resp, input bit lru, input bit sd,
                                        input bit cd, input bit mux, input bit pr,
                                        input bit pw, input bit pas, input int aw,
                                        input int lw);
        logic [31:0] r;
        r       = '0;
        r[18]   = resp;
        r[17]   = lru;
        r[16]   = sd;
        r[15]   = cd;
        r[14]   = mux;
        r[13]   = pr;
        r[12]   = pw;
        r[11]   = pas;
        r[10:8] = aw[2:0];
        r[7:0]  = lw[7:0];
        return r;
    endfunction

    function automatic logic [31:0] hit_read(input int aw);
        return pat(1, 1, 0, 0, 0, 0, 0, 0, aw, 0);
    endfunction
    function automatic logic [31:0] hit_write(input int aw, input int lw);
        return pat(1, 1, 1, 0, 1, 0, 0, 0, aw, lw);
    endfunction
    function automatic logic [31:0] fetch(input int aw);
        return pat(0, 0, 0, 0, 0, 1, 0, 0, aw, 0);
    endfunction
    function automatic logic [31:0] wback(input int aw);
        return pat(0, 0, 0, 0, 0, 0, 1, 1, aw, 0);
    endfunction
    function automatic logic [31:0] alloc(input int aw, input int lw);
        return pat(0, 0, 0, 1, 0, 0, 0, 0, aw, lw);
    endfunction

    task automatic push2(input string name, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.v    = v;
        q2.push_back(e);
    endtask

    task automatic push4(input string name, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.v    = v;
        q4.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // --------------------------------------------------------------- monitors
    always @(negedge clk) begin
        logic [31:0] o;
        exp_t        e;
        o = obs2();
        if (o != 32'h0) begin
            check("d2_pmem_exclusive", 32'(bus2.pmem_read & bus2.pmem_write), 32'h0);
            if (q2.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL d2_unexpected_output: got %h, required no activity (t=%0t)", o, $time);
            end else begin
                e = q2.pop_front();
                check(e.name, o, e.v);
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] o;
        exp_t        e;
        o = obs4();
        if (o != 32'h0) begin
            check("d4_pmem_exclusive", 32'(bus4.pmem_read & bus4.pmem_write), 32'h0);
            if (q4.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL d4_unexpected_output: got %h, required no activity (t=%0t)", o, $time);
            end else begin
                e = q4.pop_front();
                check(e.name, o, e.v);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // --------------------------------------------------------------- stimulus
    initial begin
        rst_n          = 1'b0;
        bus2.mem_read  = 1'b1;
        bus2.mem_write = 1'b0;
        bus2.pmem_resp = 1'b0;
        bus2.way_hit   = 2'b10;
        bus2.way_valid = 2'b11;
        bus2.way_dirty = 2'b00;
        bus2.lru_way   = 1'b0;
        bus4.mem_read  = 1'b0;
        bus4.mem_write = 1'b1;
        bus4.pmem_resp = 1'b0;
        bus4.way_hit   = 4'b0001;
        bus4.way_valid = 4'b1111;
        bus4.way_dirty = 4'b0000;
        bus4.lru_way   = 2'd0;

        // Reset with live hitting requests: outputs must stay quiet.
        #12;
        check("rst_d2_quiet", obs2(), 32'h0);
        check("rst_d4_quiet", obs4(), 32'h0);
        bus4.mem_write = 1'b0;
        bus4.way_hit   = 4'b0000;
        cyc();

        // First cycle after release: read hit on way 1, WAYS=2.
        rst_n = 1'b1;
        push2("d2_read_hit_way1", hit_read(1));
        cyc();

        // Idle with a stray pmem_resp: nothing moves.
        bus2.mem_read  = 1'b0;
        bus2.way_hit   = 2'b00;
        bus2.pmem_resp = 1'b1;
        @(negedge clk);
        check("d2_idle_stray_pmem_resp", obs2(), 32'h0);
        cyc();
        bus2.pmem_resp = 1'b0;

        // Write miss, way 1 invalid -> FETCH x3, ALLOCATE way 1, write hit.
        push2("d2_wmiss_fetch_c1", fetch(1));
        push2("d2_wmiss_fetch_c2", fetch(1));
        push2("d2_wmiss_fetch_c3", fetch(1));
        push2("d2_wmiss_alloc", alloc(1, 2));
        push2("d2_wmiss_write_hit", hit_write(1, 2));
        bus2.mem_write = 1'b1;
        bus2.way_valid = 2'b01;
        bus2.way_hit   = 2'b00;
        @(negedge clk);
        check("d2_miss_detect_quiet", obs2(), 32'h0);
        cyc();
        cyc();
        cyc();
        bus2.pmem_resp = 1'b1;
        cyc();
        bus2.pmem_resp = 1'b0;
        cyc();
        bus2.way_hit   = 2'b10;
        bus2.way_valid = 2'b11;
        cyc();
        bus2.mem_write = 1'b0;
        bus2.way_hit   = 2'b00;
        cyc();

        // Read miss, all valid, clean LRU 0; LRU flips to 1 mid-FETCH.
        push2("d2_lru_fetch_c1", fetch(0));
        push2("d2_lru_fetch_c2", fetch(0));
        push2("d2_lru_alloc_latched", alloc(0, 1));
        push2("d2_lru_read_hit", hit_read(0));
        bus2.mem_read  = 1'b1;
        bus2.way_valid = 2'b11;
        bus2.lru_way   = 1'b0;
        cyc();
        bus2.lru_way   = 1'b1;
        cyc();
        bus2.pmem_resp = 1'b1;
        cyc();
        bus2.pmem_resp = 1'b0;
        cyc();
        bus2.way_hit   = 2'b01;
        cyc();
        bus2.mem_read  = 1'b0;
        bus2.way_hit   = 2'b00;
        bus2.lru_way   = 1'b0;
        cyc();

        // Read and write together on a hit: write path, single response.
        push2("d2_rw_both_write_hit", hit_write(0, 1));
        bus2.mem_read  = 1'b1;
        bus2.mem_write = 1'b1;
        bus2.way_hit   = 2'b01;
        cyc();
        bus2.mem_read  = 1'b0;
        bus2.mem_write = 1'b0;
        bus2.way_hit   = 2'b00;
        cyc();

        // Reset during FETCH: pmem_read drops at once, no ALLOCATE afterwards.
        push2("d2_pre_reset_fetch", fetch(1));
        bus2.mem_read  = 1'b1;
        bus2.way_valid = 2'b01;
        cyc();
        @(negedge clk);
        #2;
        rst_n          = 1'b0;
        bus2.mem_read  = 1'b0;
        bus2.pmem_resp = 1'b1;
        #1;
        check("d2_rst_fetch_pmem_read", 32'(bus2.pmem_read), 32'h0);
        check("d2_rst_fetch_quiet", obs2(), 32'h0);
        cyc();
        bus2.pmem_resp = 1'b0;
        #2;
        rst_n          = 1'b1;
        bus2.way_valid = 2'b11;
        cyc();
        cyc();
        cyc();
        @(negedge clk);
        check("d2_post_reset_idle", obs2(), 32'h0);
        cyc();

        // WAYS=4: read miss, all valid, LRU way 2 dirty -> WRITEBACK x2,
        // FETCH x2, ALLOCATE way 2, read hit.
        push4("d4_wb_c1", wback(2));
        push4("d4_wb_c2", wback(2));
        push4("d4_wb_fetch_c1", fetch(2));
        push4("d4_wb_fetch_c2", fetch(2));
        push4("d4_wb_alloc", alloc(2, 4));
        push4("d4_wb_read_hit", hit_read(2));
        bus4.mem_read  = 1'b1;
        bus4.way_valid = 4'b1111;
        bus4.way_dirty = 4'b0100;
        bus4.lru_way   = 2'd2;
        bus4.way_hit   = 4'b0000;
        cyc();
        cyc();
        bus4.pmem_resp = 1'b1;
        cyc();
        bus4.pmem_resp = 1'b0;
        cyc();
        bus4.pmem_resp = 1'b1;
        cyc();
        bus4.pmem_resp = 1'b0;
        cyc();
        bus4.way_hit   = 4'b0100;
        cyc();
        bus4.way_hit   = 4'b0000;
        bus4.mem_read  = 1'b0;
        cyc();

        // Two hit bits: lowest index wins.
        push4("d4_multi_hit_lowest", hit_read(1));
        bus4.mem_read = 1'b1;
        bus4.way_hit  = 4'b1010;
        cyc();
        bus4.mem_read = 1'b0;
        bus4.way_hit  = 4'b0000;
        cyc();

        // Write miss with way 2 invalid (its dirty bit is stale): victim is
        // the invalid way, not the LRU, and no write-back happens.
        push4("d4_inv_fetch", fetch(2));
        push4("d4_inv_alloc", alloc(2, 4));
        push4("d4_inv_write_hit", hit_write(2, 4));
        bus4.mem_write = 1'b1;
        bus4.way_valid = 4'b1011;
        bus4.way_dirty = 4'b0100;
        bus4.lru_way   = 2'd3;
        cyc();
        bus4.pmem_resp = 1'b1;
        cyc();
        bus4.pmem_resp = 1'b0;
        cyc();
        bus4.way_hit   = 4'b0100;
        bus4.way_valid = 4'b1111;
        cyc();
        bus4.mem_write = 1'b0;
        bus4.way_hit   = 4'b0000;
        cyc();
        cyc();
        @(negedge clk);
        check("d4_final_idle", obs4(), 32'h0);

        #1;
        check("d2_queue_drained", 32'(q2.size()), 32'h0);
        check("d4_queue_drained", 32'(q4.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_wb_cache_control
